// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one cipher round per clock with on-the-fly key
// expansion. KEY_BITS selects AES-128 (10 rounds) or AES-256 (14 rounds).
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [127:0]        out_last_key,
  output logic                busy,
  output logic [3:0]          round_cnt
);
  localparam int NR = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = sbox(s[i*8 +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Four-word chained XOR that derives the next 128 key bits from the previous four words.
  function automatic logic [127:0] expand(input logic [127:0] prev, input logic [31:0] temp);
    logic [31:0] w0, w1, w2, w3;
    w0 = prev[127:96] ^ temp;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t              fsm_q, fsm_d;
  logic [127:0]        state_q;
  logic [KEY_BITS-1:0] key_q, key_next;
  logic [3:0]          round_q;
  logic [127:0]        round_key;
  logic [127:0]        round_out;
  logic [127:0]        sr_out;
  logic [31:0]         key_temp;
  logic                accept;

  if (KEY_BITS == 256) begin : g_key256
    logic [127:0] new_half;
    // Window {A,B}: round 1 uses B as loaded; later rounds expand N and shift to {B,N}.
    always_comb begin
      if (round_q[0]) key_temp = sub_word(key_q[31:0]);
      else            key_temp = sub_word(rot_word(key_q[31:0])) ^ {rcon(round_q >> 1), 24'h0};
      new_half = expand(key_q[255:128], key_temp);
      if (round_q == 4'd1) begin
        round_key = key_q[127:0];
        key_next  = key_q;
      end else begin
        round_key = new_half;
        key_next  = {key_q[127:0], new_half};
      end
    end
  end else begin : g_key128
    always_comb begin
      key_temp  = sub_word(rot_word(key_q[31:0])) ^ {rcon(round_q), 24'h0};
      round_key = expand(key_q, key_temp);
      key_next  = round_key;
    end
  end

  always_comb begin
    sr_out    = shift_rows(sub_bytes(state_q));
    round_out = ((round_q == LAST_ROUND) ? sr_out : mix_columns(sr_out)) ^ round_key;
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid must not depend on ready, and in_ready may follow out_ready combinationally.
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == ROUND);
    if (accept) begin
      fsm_d = ROUND;
    end else begin
      case (fsm_q)
        ROUND:   if (round_q == LAST_ROUND) fsm_d = DONE;
        DONE:    if (out_ready) fsm_d = IDLE;
        default: fsm_d = fsm_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (accept) begin
        state_q <= in_data ^ in_key[KEY_BITS-1 -: 128];
        key_q   <= in_key;
        round_q <= 4'd1;
      end else if (fsm_q == ROUND) begin
        state_q <= round_out;
        key_q   <= key_next;
        round_q <= (round_q == LAST_ROUND) ? 4'd0 : round_q + 4'd1;
      end
    end
  end

  assign out_data     = state_q;
  assign out_last_key = key_q[127:0];
  assign round_cnt    = round_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: an AES-128 and an AES-256 instance checked against a
// FIPS-197 reference model, with directed latency, backpressure and reset cases.
module tb_aes_iter_core;
  logic         clk = 1'b0;
  logic         rst_n, sel, in_valid, out_ready;
  logic [127:0] in_data;
  logic [255:0] in_key;

  logic         in_ready_a, out_valid_a, busy_a;
  logic [127:0] out_data_a, out_last_key_a;
  logic [3:0]   round_cnt_a;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [127:0] out_data_b, out_last_key_b;
  logic [3:0]   round_cnt_b;

  logic         in_ready_m, out_valid_m, busy_m;
  logic [127:0] out_data_m, out_last_key_m;
  logic [3:0]   round_cnt_m;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [255:0] exp_q[$];
  logic [255:0] mon_exp;
  logic [7:0]   sbox_t[256];

  aes_iter_core #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
    .in_data(in_data), .in_key(in_key[127:0]), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_last_key(out_last_key_a),
    .busy(busy_a), .round_cnt(round_cnt_a));

  aes_iter_core #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(in_ready_b),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_last_key(out_last_key_b),
    .busy(busy_b), .round_cnt(round_cnt_b));

  assign in_ready_m     = sel ? in_ready_b     : in_ready_a;
  assign out_valid_m    = sel ? out_valid_b    : out_valid_a;
  assign busy_m         = sel ? busy_b         : busy_a;
  assign out_data_m     = sel ? out_data_b     : out_data_a;
  assign out_last_key_m = sel ? out_last_key_b : out_last_key_a;
  assign round_cnt_m    = sel ? round_cnt_b    : round_cnt_a;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Full FIPS-197 expansion into w[], then byte-array rounds; returns {ciphertext, round key Nr}.
  task automatic ref_aes(input bit k256, input logic [127:0] pt, input logic [255:0] key,
                         output logic [255:0] res);
    int nk, nr;
    logic [31:0] w[60];
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [31:0] temp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] ct, lk;
    nk = k256 ? 8 : 4;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k256 ? key[255-32*i -: 32] : key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word_ref(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i + 4*(i%4)) % 16]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != nr) begin
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    lk = {w[4*nr], w[4*nr+1], w[4*nr+2], w[4*nr+3]};
    res = {ct, lk};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected results are queued on accept and compared on consume.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid_m && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 128'(out_valid_m), 128'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_ct", out_data_m, mon_exp[255:128]);
          check("sb_last_key", out_last_key_m, mon_exp[127:0]);
        end
      end
      if (in_valid && in_ready_m) begin
        ref_aes(sel, in_data, in_key, mon_exp);
        exp_q.push_back(mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input bit k256, input logic [127:0] pt, input logic [255:0] key);
    int n;
    n = 0;
    sel = k256; in_data = pt; in_key = key; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_m && n < 50);
    check("accept_ready", 128'(in_ready_m), 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (as 1) until out_valid; returns at that negedge.
  task automatic wait_out(input int exp_edges, input bit toggle, input string tag);
    int edges;
    edges = 1;
    forever begin
      @(negedge clk);
      if (out_valid_m || edges > 40) break;
      check("busy_round", 128'({busy_m, round_cnt_m}), 128'({1'b1, 4'(edges)}));
      step();
      edges++;
      if (toggle) begin
        in_data = rand128();
        in_key  = {rand128(), rand128()};
      end
    end
    check(tag, 128'(edges), 128'(exp_edges));
  endtask

  task automatic consume();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] bp_exp;
    logic [127:0] pa;
    logic [255:0] ka;
    int last_acc, n, nr;
    bit seen_valid;

    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_ctl_128", 128'({in_ready_a, out_valid_a, busy_a, round_cnt_a}), 128'h40);
    check("rst_data_128", out_data_a, 128'd0);
    check("rst_key_128", out_last_key_a, 128'd0);
    check("rst_ctl_256", 128'({in_ready_b, out_valid_b, busy_b, round_cnt_b}), 128'h40);
    check("rst_data_256", out_data_b, 128'd0);
    check("rst_key_256", out_last_key_b, 128'd0);
    step();

    send(1'b0, 128'h3243f6a8885a308d313198a2e0370734, {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
    wait_out(11, 1'b0, "latency_128");
    check("fips_ct_a", out_data_m, 128'h3925841d02dc09fbdc118597196a0b32);
    consume();
    @(negedge clk);
    check("idle_after_out", 128'({in_ready_m, out_valid_m, busy_m, round_cnt_m}), 128'h40);
    step();

    send(1'b0, 128'h00112233445566778899aabbccddeeff, {128'h0, 128'h000102030405060708090a0b0c0d0e0f});
    wait_out(11, 1'b1, "latency_128_toggle");
    check("fips_ct_b", out_data_m, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("fips_last_key_b", out_last_key_m, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    consume();

    send(1'b1, 128'h00112233445566778899aabbccddeeff,
         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    wait_out(15, 1'b1, "latency_256");
    check("fips_ct_256", out_data_m, 128'h8ea2b7ca516745bfeafc49904b496089);
    consume();

    // Backpressure, then a second block accepted in the consuming cycle.
    pa = rand128();
    ka = {128'h0, rand128()};
    ref_aes(1'b0, pa, ka, bp_exp);
    send(1'b0, pa, ka);
    wait_out(11, 1'b0, "latency_bp");
    step();
    in_data = rand128(); in_key = {128'h0, rand128()}; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_ctl", 128'({out_valid_m, in_ready_m}), 128'h2);
      check("bp_data", out_data_m, bp_exp[255:128]);
      check("bp_last_key", out_last_key_m, bp_exp[127:0]);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 128'(in_ready_m), 128'd1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    wait_out(11, 1'b0, "latency_b2b");
    consume();

    // Reset in the middle of the rounds.
    send(1'b0, rand128(), {128'h0, rand128()});
    repeat (4) @(negedge clk);
    check("pre_rst_round", 128'(round_cnt_m), 128'd4);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_round5", 128'(round_cnt_m), 128'd5);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", 128'({in_ready_m, out_valid_m, busy_m, round_cnt_m}), 128'h40);
    check("mid_rst_data", out_data_m, 128'd0);
    check("mid_rst_key", out_last_key_m, 128'd0);
    seen_valid = 1'b0;
    repeat (14) begin
      step();
      @(negedge clk);
      if (out_valid_m) seen_valid = 1'b1;
    end
    check("no_partial_out", 128'(seen_valid), 128'd0);
    step();
    send(1'b0, rand128(), {128'h0, rand128()});
    wait_out(11, 1'b1, "latency_after_rst");
    consume();

    // Reset and accept on the same edge.
    in_data = rand128(); in_key = {128'h0, rand128()}; in_valid = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_wins", 128'({in_ready_m, out_valid_m, busy_m, round_cnt_m}), 128'h40);
    step();

    // Streaming with out_ready tied high: one block every Nr+1 cycles.
    for (int k = 0; k < 2; k++) begin
      nr = (k == 1) ? 14 : 10;
      sel = k[0];
      out_ready = 1'b1;
      last_acc = 0;
      for (int b = 0; b < 5; b++) begin
        in_data = rand128(); in_key = {rand128(), rand128()}; in_valid = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!in_ready_m && n < 40);
        check("stream_accept", 128'(in_ready_m), 128'd1);
        if (b > 0) check("stream_gap", 128'(cyc - last_acc), 128'(nr + 1));
        last_acc = cyc;
        step();
      end
      in_valid = 1'b0;
      repeat (nr + 3) step();
      out_ready = 1'b0;
    end

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
